// File: rtl/opb_dec_pkg.sv
// Shared types and constants for the OPB decoder-port arbiter.
package opb_dec_pkg;

    localparam int OPB_ADDR_W = 32;
    localparam int OPB_DATA_W = 32;
    localparam int OPB_ID_W   = 3;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } opb_state_t;

    // Round-robin pointer advance: the master after the winner, wrapping to 0.
    function automatic logic [2:0] rr_next_ptr(input logic [2:0] idx, input int num_req);
        logic [2:0] nxt;
        if (int'(idx) >= (num_req - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/opb_dec_arbiter_rr.sv
// Combinational round-robin winner select: first set request at or above
// the pointer, wrapping modulo NUM_REQ. The pointer itself lives in the parent.
module rr_arbiter
    import opb_dec_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [2:0]         o_idx,
    output logic               o_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Scan requests starting at the pointer; the first hit wins.
    always_comb begin
        int   cand;
        logic hit;
        o_grant = '0;
        o_idx   = 3'd0;
        o_valid = 1'b0;
        cand    = 0;
        hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand    = (int'(i_ptr) + k) % NUM_REQ;
            hit     = ~o_valid & i_req[IDX_W'(cand)];
            o_grant[IDX_W'(cand)] = o_grant[IDX_W'(cand)] | hit;
            o_idx   = hit ? 3'(cand) : o_idx;
            o_valid = o_valid | hit;
        end
    end

endmodule

// File: rtl/opb_dec_arbiter.sv
// Shares the single address-decoder port among NUM_REQ local masters.
// Each access is one decoder strobe, a fixed read-latency wait, then a
// one-cycle ACK to the winner. All outputs come straight from registers.
module opb_dec_arbiter
    import opb_dec_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = OPB_ADDR_W,
    parameter int DATA_W  = OPB_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic                      OPB_CLK,
    input  logic                      OPB_RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        REQ_WE,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [DATA_W-1:0]         RDATA,
    output logic [2:0]                GRANT_ID,
    output logic                      BUSY,
    output logic [ADDR_W-1:0]         DEC_ADDR,
    output logic                      DEC_RE,
    output logic                      DEC_WE,
    output logic [DATA_W-1:0]         DEC_WDATA,
    input  logic [DATA_W-1:0]         DEC_DO
);

    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    opb_state_t          r_state,      w_state_nxt;
    logic [2:0]          r_ptr,        w_ptr_nxt;
    logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
    logic                r_we,         w_we_nxt;
    logic [NUM_REQ-1:0]  r_grant_oh,   w_grant_oh_nxt;
    logic [ADDR_W-1:0]   r_dec_addr,   w_dec_addr_nxt;
    logic [DATA_W-1:0]   r_dec_wdata,  w_dec_wdata_nxt;
    logic                r_dec_re,     w_dec_re_nxt;
    logic                r_dec_we,     w_dec_we_nxt;
    logic [NUM_REQ-1:0]  r_ack,        w_ack_nxt;
    logic [DATA_W-1:0]   r_rdata,      w_rdata_nxt;
    logic [2:0]          r_grant_id,   w_grant_id_nxt;
    logic                r_busy,       w_busy_nxt;

    logic [NUM_REQ-1:0]  w_grant;
    logic [2:0]          w_idx;
    logic                w_valid;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_we;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // One-hot mux of the winning master's address, write data and direction.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_addr  = w_sel_addr  | (REQ_ADDR[i*ADDR_W +: ADDR_W]  & {ADDR_W{w_grant[i]}});
            w_sel_wdata = w_sel_wdata | (REQ_WDATA[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
            w_sel_we    = w_sel_we    | (REQ_WE[i] & w_grant[i]);
        end
    end

    // Next-state and next-output logic; strobes and ACK are single-cycle pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_we_nxt        = r_we;
        w_grant_oh_nxt  = r_grant_oh;
        w_dec_addr_nxt  = r_dec_addr;
        w_dec_wdata_nxt = r_dec_wdata;
        w_dec_re_nxt    = 1'b0;
        w_dec_we_nxt    = 1'b0;
        w_ack_nxt       = '0;
        w_rdata_nxt     = r_rdata;
        w_grant_id_nxt  = r_grant_id;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt     = ST_ISSUE;
                    w_we_nxt        = w_sel_we;
                    w_grant_oh_nxt  = w_grant;
                    w_dec_addr_nxt  = w_sel_addr;
                    w_dec_wdata_nxt = w_sel_wdata;
                    w_grant_id_nxt  = w_idx;
                    w_ptr_nxt       = rr_next_ptr(w_idx, NUM_REQ);
                    w_dec_re_nxt    = ~w_sel_we;
                    w_dec_we_nxt    = w_sel_we;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == 8'd0) begin
                    if (!r_we) begin
                        w_rdata_nxt = DEC_DO;
                    end else begin
                        w_rdata_nxt = r_rdata;
                    end
                    w_ack_nxt   = r_grant_oh;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous reset that aborts any access.
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            r_grant_oh  <= '0;
            r_dec_addr  <= '0;
            r_dec_wdata <= '0;
            r_dec_re    <= 1'b0;
            r_dec_we    <= 1'b0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_grant_id  <= 3'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_grant_oh  <= w_grant_oh_nxt;
            r_dec_addr  <= w_dec_addr_nxt;
            r_dec_wdata <= w_dec_wdata_nxt;
            r_dec_re    <= w_dec_re_nxt;
            r_dec_we    <= w_dec_we_nxt;
            r_ack       <= w_ack_nxt;
            r_rdata     <= w_rdata_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign ACK       = r_ack;
    assign RDATA     = r_rdata;
    assign GRANT_ID  = r_grant_id;
    assign BUSY      = r_busy;
    assign DEC_ADDR  = r_dec_addr;
    assign DEC_RE    = r_dec_re;
    assign DEC_WE    = r_dec_we;
    assign DEC_WDATA = r_dec_wdata;

endmodule

// File: tb/tb_opb_dec_arbiter.sv
// Directed bench for opb_dec_arbiter: default build (RD_LAT=1) plus an
// RD_LAT=3 instance sharing the clock and reset.
module tb_opb_dec_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, req_we;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  dec_do;
    logic [3:0]   ack;
    logic [31:0]  rdata, dec_addr, dec_wdata;
    logic [2:0]   grant_id;
    logic         busy, dec_re, dec_we;

    logic [3:0]   req3, req_we3;
    logic [127:0] req_addr3, req_wdata3;
    logic [31:0]  dec_do3;
    logic [3:0]   ack3;
    logic [31:0]  rdata3, dec_addr3, dec_wdata3;
    logic [2:0]   grant_id3;
    logic         busy3, dec_re3, dec_we3;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    opb_dec_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .OPB_CLK(clk), .OPB_RST(rst), .REQ(req), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .ACK(ack), .RDATA(rdata),
        .GRANT_ID(grant_id), .BUSY(busy), .DEC_ADDR(dec_addr), .DEC_RE(dec_re),
        .DEC_WE(dec_we), .DEC_WDATA(dec_wdata), .DEC_DO(dec_do)
    );

    opb_dec_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
        .OPB_CLK(clk), .OPB_RST(rst), .REQ(req3), .REQ_WE(req_we3),
        .REQ_ADDR(req_addr3), .REQ_WDATA(req_wdata3), .ACK(ack3), .RDATA(rdata3),
        .GRANT_ID(grant_id3), .BUSY(busy3), .DEC_ADDR(dec_addr3), .DEC_RE(dec_re3),
        .DEC_WE(dec_we3), .DEC_WDATA(dec_wdata3), .DEC_DO(dec_do3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_we[i]           = we;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b0; req_we = 4'b0; req_addr = '0; req_wdata = '0; dec_do = 32'h0;
        req3 = 4'b0; req_we3 = 4'b0; req_addr3 = '0; req_wdata3 = '0; dec_do3 = 32'h0;
        tick; tick;
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL rst_ack: got %h expected %h", ack, 4'b0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if ({dec_re, dec_we} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {dec_re, dec_we}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_gid: got %0d expected 0", grant_id); end
        checks++; if (dec_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", dec_addr); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        int g;
        logic [31:0] exp_rd;
        for (int m = 0; m < 4; m++) set_master(m, 1'b0, 32'h100 + 32'(m*4), 32'h0);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            exp_rd = 32'h1000_0000 + 32'(g) + 32'(n*16);
            tick;
            checks++; if (grant_id !== 3'(g)) begin errors++; $display("FAIL rr_gid%0d: got %0d expected %0d", n, grant_id, g); end
            checks++; if ({dec_re, dec_we} !== 2'b10) begin errors++; $display("FAIL rr_strobe%0d: got %b expected 10", n, {dec_re, dec_we}); end
            checks++; if (dec_addr !== 32'h100 + 32'(g*4)) begin errors++; $display("FAIL rr_addr%0d: got %h expected %h", n, dec_addr, 32'h100 + 32'(g*4)); end
            tick;
            checks++; if (dec_re !== 1'b0) begin errors++; $display("FAIL rr_re_low%0d: got %b expected 0", n, dec_re); end
            dec_do = exp_rd;
            tick;
            checks++; if (ack !== (4'b0001 << g)) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", n, ack, 4'b0001 << g); end
            checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rr_rdata%0d: got %h expected %h", n, rdata, exp_rd); end
            tick;
            checks++; if ({busy, ack} !== 5'b0) begin errors++; $display("FAIL rr_idle%0d: got %b expected 00000", n, {busy, ack}); end
            last_rd = exp_rd;
        end
        req = 4'b0;
        tick;
    endtask

    task automatic test_single_write;
        set_master(2, 1'b1, 32'h0000_0040, 32'h0000_00FF);
        dec_do = 32'hDEAD_BEEF;
        req = 4'b0100;
        tick;
        checks++; if ({dec_re, dec_we} !== 2'b01) begin errors++; $display("FAIL wr_strobe: got %b expected 01", {dec_re, dec_we}); end
        checks++; if (dec_wdata !== 32'h0000_00FF) begin errors++; $display("FAIL wr_wdata: got %h expected %h", dec_wdata, 32'hFF); end
        checks++; if (dec_addr !== 32'h0000_0040) begin errors++; $display("FAIL wr_addr: got %h expected %h", dec_addr, 32'h40); end
        checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL wr_gid: got %0d expected 2", grant_id); end
        tick;
        checks++; if ({dec_re, dec_we} !== 2'b00) begin errors++; $display("FAIL wr_strobe_low: got %b expected 00", {dec_re, dec_we}); end
        tick;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL wr_ack: got %b expected 0100", ack); end
        checks++; if (rdata !== last_rd) begin errors++; $display("FAIL wr_rdata_kept: got %h expected %h", rdata, last_rd); end
        req = 4'b0;
        set_master(2, 1'b0, 32'h0, 32'h0);
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b expected 0", busy); end
    endtask

    task automatic test_pointer_wrap;
        set_master(3, 1'b0, 32'h300, 32'h0);
        set_master(0, 1'b0, 32'h200, 32'h0);
        req = 4'b1001;
        tick;
        checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL wrap_gid3: got %0d expected 3", grant_id); end
        checks++; if (dec_addr !== 32'h300) begin errors++; $display("FAIL wrap_addr3: got %h expected 300", dec_addr); end
        tick;
        dec_do = 32'h3333_0003;
        tick;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_ack3: got %b expected 1000", ack); end
        req = 4'b0001;
        tick;
        tick;
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL wrap_gid0: got %0d expected 0", grant_id); end
        checks++; if (dec_addr !== 32'h200) begin errors++; $display("FAIL wrap_addr0: got %h expected 200", dec_addr); end
        tick;
        dec_do = 32'h0000_0200;
        tick;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack0: got %b expected 0001", ack); end
        req = 4'b0;
        tick;
    endtask

    task automatic test_single_read;
        set_master(0, 1'b0, 32'h0000_0030, 32'h0);
        req = 4'b0001;
        tick;
        checks++; if ({dec_re, dec_we} !== 2'b10) begin errors++; $display("FAIL rd_strobe: got %b expected 10", {dec_re, dec_we}); end
        checks++; if (dec_addr !== 32'h30) begin errors++; $display("FAIL rd_addr: got %h expected 30", dec_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b expected 1", busy); end
        tick;
        dec_do = 32'hA5A5_0001;
        checks++; if ({dec_re, ack} !== 5'b0) begin errors++; $display("FAIL rd_wait: got %b expected 00000", {dec_re, ack}); end
        checks++; if (dec_addr !== 32'h30) begin errors++; $display("FAIL rd_addr_held: got %h expected 30", dec_addr); end
        tick;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rd_ack: got %b expected 0001", ack); end
        checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_rdata: got %h expected a5a50001", rdata); end
        req = 4'b0;
        tick;
        checks++; if ({busy, ack} !== 5'b0) begin errors++; $display("FAIL rd_done: got %b expected 00000", {busy, ack}); end
    endtask

    task automatic test_reset_mid_op;
        set_master(2, 1'b0, 32'h50, 32'h0);
        req = 4'b0100;
        tick;
        tick;
        rst = 1'b1;
        set_master(1, 1'b0, 32'h60, 32'h0);
        set_master(3, 1'b0, 32'h70, 32'h0);
        req = 4'b1010;
        tick;
        checks++; if ({busy, ack, dec_re, dec_we} !== 7'b0) begin errors++; $display("FAIL rstm_outs: got %b expected 0000000", {busy, ack, dec_re, dec_we}); end
        checks++; if ((grant_id !== 3'd0) || (rdata !== 32'h0)) begin errors++; $display("FAIL rstm_regs: got %0d/%h expected 0/0", grant_id, rdata); end
        rst = 1'b0;
        tick;
        checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL rstm_gid: got %0d expected 1", grant_id); end
        checks++; if (dec_addr !== 32'h60) begin errors++; $display("FAIL rstm_addr: got %h expected 60", dec_addr); end
        tick;
        dec_do = 32'h0000_0006;
        tick;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rstm_ack: got %b expected 0010", ack); end
        req = 4'b0;
        tick;
    endtask

    task automatic test_rd_lat3;
        req_we3 = 4'b0;
        req_addr3[31:0] = 32'h80;
        req3 = 4'b0001;
        tick;
        checks++; if (dec_re3 !== 1'b1) begin errors++; $display("FAIL lat3_re: got %b expected 1", dec_re3); end
        tick;
        dec_do3 = 32'h0000_1111;
        tick;
        dec_do3 = 32'h0000_2222;
        checks++; if (ack3 !== 4'b0) begin errors++; $display("FAIL lat3_ack_t3: got %b expected 0000", ack3); end
        tick;
        dec_do3 = 32'h3333_0003;
        checks++; if (ack3 !== 4'b0) begin errors++; $display("FAIL lat3_ack_t4: got %b expected 0000", ack3); end
        tick;
        checks++; if (ack3 !== 4'b0001) begin errors++; $display("FAIL lat3_ack_t5: got %b expected 0001", ack3); end
        checks++; if (rdata3 !== 32'h3333_0003) begin errors++; $display("FAIL lat3_rdata: got %h expected 33330003", rdata3); end
        req3 = 4'b0;
        tick;
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_idle: got %b expected 0", busy3); end
    endtask

    initial begin
        last_rd = 32'h0;
        test_reset;
        test_round_robin;
        test_single_write;
        test_pointer_wrap;
        test_single_read;
        test_reset_mid_op;
        test_rd_lat3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
